// File: rtl/apb_regbank_pkg.sv
// Shared types and helpers for the APB register-bank slave.
package apb_regbank_pkg;

  localparam int MAX_WAIT = 15;
  localparam int IDX_W    = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    SETUP  = 3'b010,
    ACCESS = 3'b100
  } state_e;

  typedef struct packed {
    logic             err;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Base compare happens before the subtraction, so the offset never wraps.
  function automatic dec_t decode_index(input logic [31:0] addr, input logic [31:0] base,
                                        input int stride_log2, input int num_regs);
    logic [31:0] off;
    logic [31:0] full_idx;
    logic [31:0] mask;
    dec_t        d;
    d = '0;
    if (addr < base) begin
      d.err = 1'b1;
    end else begin
      off      = addr - base;
      full_idx = off >> stride_log2;
      mask     = (32'd1 << stride_log2) - 32'd1;
      if (full_idx >= 32'(num_regs)) d.err = 1'b1;
      if ((off & mask) != '0)        d.err = 1'b1;
      d.idx = full_idx[IDX_W-1:0];
    end
    return d;
  endfunction

endpackage

// File: rtl/apb_regbank_if.sv
// APB bus bundle; pstrb exists only when APB_REGBANK_WSTRB_EN is defined.
interface apb_regbank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
`ifdef APB_REGBANK_WSTRB_EN
  logic [DATA_WIDTH/8-1:0] pstrb;
`endif
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

`ifdef APB_REGBANK_WSTRB_EN
  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb,
                  input  pready, prdata, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb,
                  output pready, prdata, pslverr);
`else
  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  pready, prdata, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output pready, prdata, pslverr);
`endif
endinterface

// File: rtl/apb_regbank_storage.sv
// Register array: byte-enable writes, read-only muxing from hardware status, flat image out.
module apb_regbank_storage
  import apb_regbank_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_REGS   = 16,
  parameter logic [63:0] RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           i_we,
  input  logic [IDX_W-1:0]               i_idx,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_strb,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] i_hw_ro_data,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_q
);
  localparam int NB = DATA_WIDTH / 8;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;

  // RO slots are never written, so they hold 0 and read 0 on the image.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_regs <= '0;
    end else if (i_we) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (i_idx == IDX_W'(i) && !RO_MASK[i])
          for (int b = 0; b < NB; b++)
            if (i_strb[b]) r_regs[i][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (i_idx == IDX_W'(i))
        o_rdata = RO_MASK[i] ? i_hw_ro_data[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
  end

  assign o_reg_q = r_regs;

endmodule

// File: rtl/apb_regbank_slave.sv
// APB slave with register bank, wait states and PSLVERR; byte strobes under APB_REGBANK_WSTRB_EN.
module apb_regbank_slave
  import apb_regbank_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    NUM_REGS    = 16,
  parameter int                    STRIDE_LOG2 = 6,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0,
  parameter logic [63:0]           RO_MASK     = '0
) (
  input  logic                           clk,
  input  logic                           rstn,
  apb_regbank_if.slave                   apb,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_ro_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int WS = (WAIT_STATES > MAX_WAIT) ? MAX_WAIT : WAIT_STATES;

  state_e                r_state, w_next;
  logic [3:0]            r_cnt;
  logic                  r_wr, r_err;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_wdata, w_rdata;
  logic [NB-1:0]         r_strb, w_bus_strb;
  dec_t                  w_dec;
  logic                  w_pready, w_we;

`ifdef APB_REGBANK_WSTRB_EN
  assign w_bus_strb = apb.pstrb;
`else
  assign w_bus_strb = '1;
`endif

  assign w_dec = decode_index(32'(apb.paddr), 32'(BASE_ADDR), STRIDE_LOG2, NUM_REGS);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (apb.psel && !apb.penable) w_next = SETUP;
      SETUP: begin
        if (!apb.psel)        w_next = IDLE;
        else if (apb.penable) w_next = ACCESS;
      end
      ACCESS: begin
        if (!apb.psel)          w_next = IDLE;
        else if (r_cnt == 4'd0) w_next = apb.penable ? IDLE : SETUP;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request is captured every SETUP cycle so a repeated setup phase relatches.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (r_state == SETUP) begin
      r_wr    <= apb.pwrite;
      r_wdata <= apb.pwdata;
      r_strb  <= w_bus_strb;
      r_idx   <= w_dec.idx;
      r_err   <= w_dec.err | (apb.pwrite & RO_MASK[w_dec.idx]);
      r_cnt   <= 4'(WS);
    end else if (r_state == ACCESS && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign w_pready    = (r_state == ACCESS) && (r_cnt == 4'd0) && apb.psel && apb.penable;
  assign w_we        = w_pready && r_wr && !r_err;
  assign apb.pready  = w_pready;
  assign apb.pslverr = w_pready && r_err;
  assign apb.prdata  = (w_pready && !r_wr && !r_err) ? w_rdata : '0;

  apb_regbank_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_storage (
    .clk          (clk),
    .rstn         (rstn),
    .i_we         (w_we),
    .i_idx        (r_idx),
    .i_wdata      (r_wdata),
    .i_strb       (r_strb),
    .i_hw_ro_data (hw_ro_data),
    .o_rdata      (w_rdata),
    .o_reg_q      (reg_q)
  );

endmodule

// File: doc/apb_regbank_slave.md
Name: apb_regbank_slave

Overview:
Parametrised APB slave with an integrated register bank, generalising the fixed 16-register, 0x40-stride slave and register file.
- Adds programmable wait states, PSLVERR on decode and read-only-write errors, read-only hardware-status registers, and a flattened register-image output to the fabric.
- Sits between the APB master/interconnect (one PSEL per slave) and local control/status logic.

Parameters:
DATA_WIDTH, 32, PWDATA/PRDATA/register width (multiple of 8).
ADDR_WIDTH, 16, PADDR width.
NUM_REGS, 16, number of registers (2..64).
STRIDE_LOG2, 6, log2 of byte stride between registers (default 0x40).
BASE_ADDR, 0, byte address of register 0.
WAIT_STATES, 0, extra access-phase cycles before PREADY (0..15).
RO_MASK, 0, bit i=1: register i is read-only, sourced from hw_ro_data.

Ports:
clk  in  1  clock.
rstn  in  1  async active-low reset.
psel  in  1  APB select.
penable  in  1  APB enable.
pwrite  in  1  1=write.
paddr  in  ADDR_WIDTH  byte address.
pwdata  in  DATA_WIDTH  write data.
pstrb  in  DATA_WIDTH/8  byte strobes; present only with APB_REGBANK_WSTRB_EN.
pready  out  1  transfer complete.
prdata  out  DATA_WIDTH  read data; valid when pready & !pwrite.
pslverr  out  1  error; valid when pready.
hw_ro_data  in  NUM_REGS*DATA_WIDTH  values for RO registers, slice i = register i.
reg_q  out  NUM_REGS*DATA_WIDTH  current RW register contents; RO slices read 0.

Behaviour:
- Reset (rstn=0, async): all RW registers 0; FSM in IDLE; wait counter 0. pready, pslverr, prdata all 0.
- FSM states:
  - IDLE: psel & !penable -> SETUP.
  - SETUP: latch paddr, pwrite, pwdata (and pstrb); compute decode error; load cnt=WAIT_STATES. Then psel & penable -> ACCESS; !psel -> IDLE; psel & !penable -> SETUP (relatch).
  - ACCESS: while cnt!=0, cnt-- each cycle. When cnt==0, the completion cycle executes and the FSM goes to SETUP if psel & !penable, else IDLE. psel=0 at any point in ACCESS: abort to IDLE, no write, pready stays 0.
- pready is combinational: (state==ACCESS) & (cnt==0) & psel & penable. Transfer takes 2+WAIT_STATES cycles from SETUP entry.
- Decode error: any of
  - paddr < BASE_ADDR
  - index = (paddr-BASE_ADDR)>>STRIDE_LOG2 >= NUM_REGS
  - offset bits [STRIDE_LOG2-1:0] nonzero
  - write to a RO register.
- pslverr = pready & error.
- Writes commit at the clk edge ending the completion cycle, and only if error=0.
- prdata = register[index] (RO: hw_ro_data slice) when pready & !pwrite & !error; otherwise 0.
- Read of a register in the same completion cycle as a write to it is impossible (single port); a read immediately following a write returns the new value.
- Address arithmetic is done in ADDR_WIDTH bits; the subtraction is never wrapped, and BASE_ADDR compare is done first.
- Reset mid-transfer: immediate return to IDLE, no write, outputs 0.

Optional Feature:
APB_REGBANK_WSTRB_EN
- Defined: pstrb port exists. Byte lane b is written only if pstrb[b]=1. pstrb=0 on a write is a legal no-op with pslverr=0. Reads ignore pstrb.
- Undefined: no pstrb port; every write updates the full word.

Decomposition:
- Package apb_regbank_pkg holds:
  - state_e typedef: IDLE/SETUP/ACCESS, one-hot.
  - function decode_index(addr), returning index and error flag.
  - constant MAX_WAIT=15.
- One natural sub-module, apb_regbank_storage: the register array with byte-enable write, RO muxing and reg_q flattening. The FSM, counter and decode live in the top module.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x0040, then read 0x0040 -> pready on the first access cycle, prdata=0xDEADBEEF, pslverr=0, reg_q slice 1=0xDEADBEEF.
- WAIT_STATES=3: read 0x0080 -> pready low for 3 access cycles, high on the 4th; transfer totals 5 cycles.
- Write to 0x0400 (index 16) and to 0x0044 (misaligned) -> pslverr=1 with pready; no register changes; read back of 0x0040 unchanged.
- RO_MASK=0x0004, hw_ro_data slice 2=0x12345678: read 0x0080 -> 0x12345678; write 0x0080 -> pslverr=1, value unaffected.
- WSTRB_EN, reg 3=0xFFFFFFFF: write 0x00000000 with pstrb=0b0101 -> reg 3=0xFF00FF00.
- Assert rstn=0 during a WAIT_STATES=3 write after SETUP -> registers all 0; pready and pslverr 0; next transfer completes normally.
